// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor datapath.
//   sub_state_e   : control states of the bit-serial subtractor
//   DEFAULT_WIDTH : default operand width
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bi, with borrow out.
// Ports:
//   a  : minuend bit
//   b  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    // Borrow when b exceeds a outright, or when the bits match and a borrow
    // is already pending.
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, bout = borrow out.
// One bit is processed per clock, LSB first, through a single fs_cell.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : a, b, bin are valid
//   in_ready  : block can accept operands (high only in IDLE)
//   a, b, bin : minuend, subtrahend, borrow in
//   out_valid : diff/bout are valid (high only in DONE)
//   out_ready : consumer accepts the result
//   diff      : difference, held until the next result is latched
//   bout      : borrow out, 1 iff a < b + bin (unsigned)
module serial_ripple_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);

    sub_state_e       state;
    sub_state_e       next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             borrow;

    logic             d_bit;
    logic             borrow_next;
    logic             last_bit;
    logic [WIDTH-1:0] d_sh_next;

    fs_cell u_fs_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (borrow_next)
    );

    // Difference bits enter at the MSB, so after WIDTH shifts bit 0 of the
    // result has walked down to position 0.
    assign d_sh_next = {d_bit, d_sh[WIDTH-1:1]};
    assign last_bit  = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = BUSY;
            BUSY:    if (last_bit)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Shift registers, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        d_sh   <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    d_sh   <= d_sh_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff <= d_sh_next;
                        bout <= borrow_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial, multi-cycle companion to the combinational ripple-carry adder in the adder datapath.
- Computes diff = a - b - bin with a borrow out, processing one bit per clock, LSB first, through a single full-subtractor cell.
- Has valid/ready handshakes on input and output, so it drops into pipelines that trade throughput for area.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), width of the bit-position counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  diff/bout are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (async assert, sync deassert handled by the system): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, counter=0, internal shift registers=0.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE), combinational from the state register only.
- IDLE: on in_valid&&in_ready at an edge:
  - load a_sh<=a, b_sh<=b, borrow<=bin, cnt<=0, d_sh<=0.
  - go to BUSY.
  - Inputs are ignored at all other times.
- BUSY, each edge:
  - d_i = a_sh[0]^b_sh[0]^borrow.
  - borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
  - d_sh shifts right with d_i entering at MSB; a_sh and b_sh shift right.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, this edge processes the last bit: go to DONE, latch diff<=final d_sh, bout<=final borrow.
- Latency: acceptance edge = edge 0; out_valid is high after edge WIDTH (8 cycles for the default); exactly WIDTH BUSY cycles.
- DONE:
  - out_valid=1; diff/bout held stable while out_valid && !out_ready.
  - On out_valid&&out_ready at an edge: go to IDLE, out_valid<=0; diff/bout keep their last value.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no accept in DONE, even if out_ready=1 in the same cycle.
- in_valid during BUSY/DONE has no effect. Operands are sampled only at the acceptance edge, so changes after acceptance do not affect the result.
- Boundaries:
  - a==b with bin=0 gives diff=0, bout=0.
  - WIDTH-bit wrap is mod 2^WIDTH.
  - bin=1 with a==b gives all-ones and bout=1.
- Reset mid-operation (BUSY or DONE) immediately returns to reset values; the partial result is discarded.
- No X propagation: all registers are reset; diff/bout never depend on unloaded state.

Decomposition:
- Shared package (adder_pkg): state enum sub_state_e {IDLE, BUSY, DONE}; constant DEFAULT_WIDTH=8.
- Sub-module: fs_cell, a combinational 1-bit full subtractor (a, b, bi -> d, bo), instantiated once and fed by the shift-register LSBs.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan:
- Basic: a=8'h05, b=8'h03, bin=0, single in_valid pulse.
  -> in_ready drops next cycle; out_valid rises exactly 8 edges after acceptance; diff=8'h02, bout=0.
- Underflow and borrow-in cases:
  - a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1.
  - a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
  - a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1.
- Max minuend: a=8'hFF, b=8'h00, bin=0 -> diff=8'hFF, bout=0. Also a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid and changing a/b.
  -> diff/bout stay constant, in_ready stays 0; on out_ready=1, one handshake then IDLE.
- Reset mid-op: assert rst_n=0 at BUSY cycle 4.
  -> outputs go to reset values immediately (async); a new operation afterwards (a=8'h10, b=8'h01) gives diff=8'h0F, bout=0.
- Randomised back-to-back: 1000 operations with random a, b, bin, in_valid and out_ready.
  -> every result matches the {bout, diff} = {1'b0,a} - b - bin model; no lost or duplicated transactions.
